// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline stall/flush controller.
// Stall/flush vectors: bit 0 = PC stage, higher bits = later stages.
package pipe_ctrl_pkg;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b1;

  localparam int unsigned MASK_W = 32;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_PEND = 1'b1
  } flush_state_e;

  // Stall mask covering stages [s:0].
  function automatic logic [MASK_W-1:0] stage_mask(input int unsigned s);
    return (MASK_W'(2) << s) - MASK_W'(1);
  endfunction

  // Flush mask covering stages below k.
  function automatic logic [MASK_W-1:0] flush_mask(input int unsigned k);
    return (MASK_W'(1) << k) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline and pipe_ctrl.
// master = pipeline side (drives requests), slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned SW         = 3,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned CNT_W      = 32
);
  logic                  rdy_in;
  logic                  glob_stall_i;
  logic [NUM_REQ-1:0]    req_i;
  logic                  flush_req_i;
  logic [SW-1:0]         flush_stage_i;
  logic                  clr_timeout_i;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  flush_pending;
  logic                  stall_timeout;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output rdy_in, glob_stall_i, req_i, flush_req_i, flush_stage_i, clr_timeout_i,
    input  stall, flush, flush_pending, stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  rdy_in, glob_stall_i, req_i, flush_req_i, flush_stage_i, clr_timeout_i,
    output stall, flush, flush_pending, stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive-stall watchdog: saturating run counter with a sticky,
// clearable timeout flag.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any,
  input  logic clr,
  output logic timeout
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;
  logic          fire;

  assign fire = (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr)
        timeout <= 1'b0;
      else if (fire)
        timeout <= 1'b1;
      // A clear that coincides with the fire condition also restarts the run.
      if ((clr && fire) || !stall_any)
        cnt <= '0;
      else if (!fire)
        cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: merges stall sources, sequences flushes
// (deferred while globally stalled) and runs a stall watchdog.
// Optional perf counters: define PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned           NUM_STAGES     = 6,
  parameter int unsigned           SW             = 3,
  parameter int unsigned           NUM_REQ        = 2,
  parameter logic [NUM_REQ*SW-1:0] REQ_STAGE      = {3'd3, 3'd2},
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter int unsigned           CNT_W          = 32
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  flush_state_e          state;
  logic [SW-1:0]         pend_k;
  logic [SW-1:0]         flush_k;
  logic                  g_stall;
  logic                  flush_fire;
  logic [NUM_STAGES-1:0] local_stall;
  logic [NUM_STAGES-1:0] fmask;
  logic [NUM_STAGES-1:0] stall_v;
  logic [NUM_STAGES-1:0] flush_v;

  assign g_stall = !bus.rdy_in || bus.glob_stall_i;

  always_comb begin
    local_stall = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++)
      if (bus.req_i[j])
        local_stall |= NUM_STAGES'(stage_mask(32'(REQ_STAGE[j*SW +: SW])));
  end

  // A queued flush is released on the first unstalled cycle, merged with
  // any redirect arriving in that same cycle.
  always_comb begin
    flush_fire = 1'b0;
    flush_k    = '0;
    if (!g_stall) begin
      if (state == FSM_PEND) begin
        flush_fire = 1'b1;
        flush_k    = (bus.flush_req_i && bus.flush_stage_i > pend_k) ? bus.flush_stage_i : pend_k;
      end else if (bus.flush_req_i) begin
        flush_fire = 1'b1;
        flush_k    = bus.flush_stage_i;
      end
    end
    fmask = flush_fire ? NUM_STAGES'(flush_mask(32'(flush_k))) : '0;
  end

  // Flushed stages must load bubbles, so flush overrides their stall.
  assign stall_v = (rst == RstEnable) ? '0 : ((g_stall ? '1 : local_stall) & ~fmask);
  assign flush_v = (rst == RstEnable) ? '0 : fmask;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state  <= FSM_IDLE;
      pend_k <= '0;
    end else begin
      case (state)
        FSM_IDLE:
          if (bus.flush_req_i && g_stall) begin
            state  <= FSM_PEND;
            pend_k <= bus.flush_stage_i;
          end
        FSM_PEND:
          if (!g_stall)
            state <= FSM_IDLE;
          else if (bus.flush_req_i && bus.flush_stage_i > pend_k)
            pend_k <= bus.flush_stage_i;
        default: state <= FSM_IDLE;
      endcase
    end
  end

  assign bus.stall         = stall_v;
  assign bus.flush         = flush_v;
  assign bus.flush_pending = (state == FSM_PEND);

  pipe_ctrl_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .stall_any(|stall_v),
    .clr      (bus.clr_timeout_i),
    .timeout  (bus.stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (|stall_v)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_fire)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule
